// File: rtl/sha1_msg_loader_if.sv
// Byte-stream port of the SHA-1 message loader.
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both high; the master holds byte_data/byte_last stable
// while byte_valid is high and byte_ready is low; byte_ready never depends
// combinationally on byte_valid.
interface sha1_msg_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, output byte_last, input byte_ready);
  modport slave  (input byte_valid, input byte_data, input byte_last, output byte_ready);
endinterface

// File: rtl/sha1_msg_loader.sv
// SHA-1 message loader: packs a byte stream big-endian into 32-bit SRAM
// words, starts the hasher, captures the digest and (optionally) writes it
// back to SRAM. Optional digest write-back: define SHA1_DIGEST_WB_EN.
// state_dbg exposes the FSM state (IDLE=0 LOAD=1 START=2 WAIT=3 WBACK=4 FIN=5).
module sha1_msg_loader #(
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic [31:0]          message_addr,
  input  logic [31:0]          digest_addr,
  sha1_msg_loader_if.slave     byte_if,
  output logic                 mem_clk,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_we,
  output logic                 start_hash,
  output logic [31:0]          message_size,
  input  logic [159:0]         hash,
  input  logic                 hash_done,
  output logic [159:0]         digest,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_WBACK = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t            state;
  logic              byte_ready_q;
  logic [ADDR_W-1:0] msg_base;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       byte_cnt;
  logic [31:0]       shift_word;
  logic [1:0]        byte_pos;
  logic [31:0]       packed_word;
  logic              accept;

  assign mem_clk           = clk;
  assign state_dbg         = state;
  assign byte_if.byte_ready = byte_ready_q;
  assign accept            = (state == S_LOAD) && byte_if.byte_valid && byte_ready_q;

`ifdef SHA1_DIGEST_WB_EN
  logic [ADDR_W-1:0] dig_base;
  logic [2:0]        wb_cnt;
  logic [31:0]       wb_word;
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{message_addr[31:ADDR_W], digest_addr[31:ADDR_W]};

  // Digest word for the current write-back slot, most significant first.
  always_comb begin
    wb_word = digest[31:0];
    case (wb_cnt)
      3'd1:    wb_word = digest[127:96];
      3'd2:    wb_word = digest[95:64];
      3'd3:    wb_word = digest[63:32];
      default: wb_word = digest[31:0];
    endcase
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{message_addr[31:ADDR_W], digest_addr};
`endif

  // Merge the incoming byte into the partially built word at its big-endian slot.
  always_comb begin
    packed_word = shift_word;
    case (byte_pos)
      2'd0:    packed_word[31:24] = byte_if.byte_data;
      2'd1:    packed_word[23:16] = byte_if.byte_data;
      2'd2:    packed_word[15:8]  = byte_if.byte_data;
      default: packed_word[7:0]   = byte_if.byte_data;
    endcase
  end

  // Job sequencer with registered outputs; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      byte_ready_q <= 1'b0;
      msg_base     <= '0;
      word_idx     <= '0;
      byte_cnt     <= '0;
      shift_word   <= '0;
      byte_pos     <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      start_hash   <= 1'b0;
      message_size <= '0;
      digest       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef SHA1_DIGEST_WB_EN
      dig_base     <= '0;
      wb_cnt       <= '0;
`endif
    end else begin
      mem_we     <= 1'b0;
      start_hash <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start) begin
            msg_base     <= message_addr[ADDR_W-1:0];
`ifdef SHA1_DIGEST_WB_EN
            dig_base     <= digest_addr[ADDR_W-1:0];
`endif
            byte_cnt     <= '0;
            word_idx     <= '0;
            shift_word   <= '0;
            byte_pos     <= '0;
            byte_ready_q <= 1'b1;
            busy         <= 1'b1;
            state        <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 32'd1;
            if (byte_pos == 2'd3 || byte_if.byte_last) begin
              mem_we     <= 1'b1;
              mem_addr   <= msg_base + word_idx;
              mem_wdata  <= packed_word;
              word_idx   <= word_idx + 1'b1;
              shift_word <= '0;
              byte_pos   <= '0;
            end else begin
              shift_word <= packed_word;
              byte_pos   <= byte_pos + 2'd1;
            end
            if (byte_if.byte_last) begin
              byte_ready_q <= 1'b0;
              start_hash   <= 1'b1;
              message_size <= byte_cnt + 32'd1;
              state        <= S_START;
            end
          end
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (hash_done) begin
            digest <= hash;
`ifdef SHA1_DIGEST_WB_EN
            mem_we    <= 1'b1;
            mem_addr  <= dig_base;
            mem_wdata <= hash[159:128];
            wb_cnt    <= 3'd1;
            state     <= S_WBACK;
`else
            done      <= 1'b1;
            state     <= S_FIN;
`endif
          end
        end
`ifdef SHA1_DIGEST_WB_EN
        S_WBACK: begin
          if (wb_cnt == 3'd5) begin
            done  <= 1'b1;
            state <= S_FIN;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= dig_base + ADDR_W'(wb_cnt);
            mem_wdata <= wb_word;
            wb_cnt    <= wb_cnt + 3'd1;
          end
        end
`endif
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_msg_loader.sv
// Self-checking bench for sha1_msg_loader: memory writes are checked against
// an expected queue filled by the byte driver and the digest driver.
module tb_sha1_msg_loader;
  localparam int ADDR_W = 16;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
`ifdef SHA1_DIGEST_WB_EN
  localparam int DONE_LAT = 6;
`else
  localparam int DONE_LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              load_start;
  logic [31:0]       message_addr;
  logic [31:0]       digest_addr;
  logic              mem_clk;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              start_hash;
  logic [31:0]       message_size;
  logic [159:0]      hash;
  logic              hash_done;
  logic [159:0]      digest;
  logic              busy;
  logic              done;
  logic [2:0]        state_dbg;

  sha1_msg_loader_if byte_if();

  sha1_msg_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .message_addr(message_addr), .digest_addr(digest_addr),
    .byte_if(byte_if),
    .mem_clk(mem_clk), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .start_hash(start_hash), .message_size(message_size),
    .hash(hash), .hash_done(hash_done), .digest(digest),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] exp_w;
  logic [ADDR_W-1:0]  cur_base;
  logic [ADDR_W-1:0]  cur_daddr;
  logic [7:0]         msg [0:63];
  int                 stalls;

  // Scoreboard: every write the DUT issues must match the head of exp_q.
  always @(posedge clk) begin
    #1;
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mem_write unexpected: addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp_w) begin
          failures++;
          $display("FAIL mem_write: addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, exp_w[ADDR_W+31:32], exp_w[31:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] maddr, input logic [31:0] daddr);
    load_start   = 1'b1;
    message_addr = maddr;
    digest_addr  = daddr;
    step();
    load_start   = 1'b0;
    cur_base     = maddr[ADDR_W-1:0];
    cur_daddr    = daddr[ADDR_W-1:0];
  endtask

  // Sends msg[0..n-1]; flags the final byte as last when finish is set.
  task automatic send_bytes(input int n, input bit finish);
    logic [31:0]       w;
    logic [ADDR_W-1:0] a;
    int widx;
    int guard;
    w = '0;
    widx = 0;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      byte_if.byte_valid = 1'b1;
      byte_if.byte_data  = msg[i];
      byte_if.byte_last  = finish && (i == n - 1);
      guard = 0;
      while (byte_if.byte_ready !== 1'b1 && guard < 20) begin
        step();
        stalls++;
        guard++;
      end
      if (guard >= 20) begin
        checks++;
        failures++;
        $display("FAIL byte_accept: byte_ready=%b after 20 cycles, required 1", byte_if.byte_ready);
        byte_if.byte_valid = 1'b0;
        byte_if.byte_last  = 1'b0;
        return;
      end
      w[31 - 8 * (i % 4) -: 8] = msg[i];
      if ((i % 4) == 3 || (finish && i == n - 1)) begin
        a = cur_base + ADDR_W'(widx);
        exp_q.push_back({a, w});
        w = '0;
        widx++;
      end
      step();
    end
    byte_if.byte_valid = 1'b0;
    byte_if.byte_last  = 1'b0;
  endtask

  // Checks the cycle right after the last byte and the move into WAIT.
  task automatic check_start(input int n);
    checks++;
    if (start_hash !== 1'b1 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL start_pulse: start_hash=%b mem_we=%b, required 1 1", start_hash, mem_we);
    end
    checks++;
    if (message_size !== 32'(n)) begin
      failures++;
      $display("FAIL message_size: got %0d, required %0d", message_size, n);
    end
    step();
    checks++;
    if (start_hash !== 1'b0 || state_dbg !== ST_WAIT) begin
      failures++;
      $display("FAIL start_one_cycle: start_hash=%b state=%0d, required 0 %0d", start_hash, state_dbg, ST_WAIT);
    end
  endtask

  task automatic finish_job(input logic [159:0] h);
    int k;
`ifdef SHA1_DIGEST_WB_EN
    for (int j = 0; j < 5; j++) begin
      logic [ADDR_W-1:0] a;
      a = cur_daddr + ADDR_W'(j);
      exp_q.push_back({a, h[159 - 32 * j -: 32]});
    end
`endif
    hash      = h;
    hash_done = 1'b1;
    step();
    hash_done = 1'b0;
    k = 1;
    checks++;
    if (digest !== h) begin
      failures++;
      $display("FAIL digest_capture: got %h, required %h", digest, h);
    end
    while (done !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    checks++;
    if (k !== DONE_LAT) begin
      failures++;
      $display("FAIL done_latency: got %0d cycles, required %0d", k, DONE_LAT);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL job_end: done=%b busy=%b state=%0d, required 0 0 %0d", done, busy, state_dbg, ST_IDLE);
    end
  endtask

  function automatic logic [159:0] rand_hash();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scenarios
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({byte_if.byte_ready, mem_we, start_hash, busy, done, state_dbg} !== 8'd0 ||
        mem_addr !== '0 || mem_wdata !== '0 || message_size !== '0 || digest !== '0) begin
      failures++;
      $display("FAIL reset_values: ready=%b we=%b start=%b busy=%b done=%b state=%0d addr=%h wdata=%h size=%h digest=%h, required all 0",
               byte_if.byte_ready, mem_we, start_hash, busy, done, state_dbg, mem_addr, mem_wdata, message_size, digest);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_three_byte();
    start_job(32'h10, 32'h80);
    checks++;
    if (busy !== 1'b1 || byte_if.byte_ready !== 1'b1 || state_dbg !== ST_LOAD) begin
      failures++;
      $display("FAIL load_entry: busy=%b ready=%b state=%0d, required 1 1 %0d", busy, byte_if.byte_ready, state_dbg, ST_LOAD);
    end
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_bytes(3, 1'b1);
    check_start(3);
    finish_job(rand_hash());
  endtask

  task automatic test_back_to_back();
    start_job(32'h100, 32'h90);
    for (int i = 0; i < 8; i++) msg[i] = 8'($urandom_range(0, 255));
    send_bytes(8, 1'b1);
    checks++;
    if (stalls !== 0) begin
      failures++;
      $display("FAIL back_to_back_stalls: got %0d, required 0", stalls);
    end
    check_start(8);
    finish_job(rand_hash());
  endtask

  task automatic test_hash_capture();
    start_job(32'h200, 32'h40);
    for (int i = 0; i < 4; i++) msg[i] = 8'($urandom_range(0, 255));
    send_bytes(4, 1'b1);
    check_start(4);
    finish_job(160'h0123456789ABCDEFFEDCBA9876543210DEADBEEF);
  endtask

  task automatic test_addr_wrap();
    start_job(32'h0000FFFF, 32'hFFFE);
    for (int i = 0; i < 5; i++) msg[i] = 8'($urandom_range(0, 255));
    send_bytes(5, 1'b1);
    check_start(5);
    finish_job(rand_hash());
  endtask

  task automatic test_ignored_inputs();
    logic [159:0] prev;
    prev = digest;
    start_job(32'h300, 32'h50);
    for (int i = 0; i < 5; i++) msg[i] = 8'($urandom_range(0, 255));
    hash      = rand_hash();
    hash_done = 1'b1;
    send_bytes(5, 1'b1);
    hash_done = 1'b0;
    checks++;
    if (digest !== prev || state_dbg !== ST_START) begin
      failures++;
      $display("FAIL hash_done_in_load: digest=%h state=%0d, required %h %0d", digest, state_dbg, prev, ST_START);
    end
    check_start(5);
    load_start         = 1'b1;
    message_addr       = 32'h999;
    digest_addr        = 32'h77;
    byte_if.byte_valid = 1'b1;
    byte_if.byte_data  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (state_dbg !== ST_WAIT || message_size !== 32'd5 || byte_if.byte_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL inputs_in_wait: state=%0d size=%0d ready=%b busy=%b, required %0d 5 0 1",
                 state_dbg, message_size, byte_if.byte_ready, busy, ST_WAIT);
      end
    end
    load_start         = 1'b0;
    byte_if.byte_valid = 1'b0;
    finish_job(rand_hash());
  endtask

  task automatic test_reset_mid_load();
    start_job(32'h20, 32'h60);
    msg[0] = 8'h11; msg[1] = 8'h22;
    send_bytes(2, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({byte_if.byte_ready, mem_we, start_hash, busy, done, state_dbg} !== 8'd0 ||
        mem_addr !== '0 || mem_wdata !== '0 || message_size !== '0 || digest !== '0) begin
      failures++;
      $display("FAIL reset_mid_load: ready=%b we=%b start=%b busy=%b done=%b state=%0d addr=%h wdata=%h size=%h digest=%h, required all 0",
               byte_if.byte_ready, mem_we, start_hash, busy, done, state_dbg, mem_addr, mem_wdata, message_size, digest);
    end
    step();
    start_job(32'h30, 32'h70);
    msg[0] = 8'hA1; msg[1] = 8'hB2; msg[2] = 8'hC3;
    send_bytes(3, 1'b1);
    check_start(3);
    finish_job(rand_hash());
  endtask

  // Sequence and final report
  initial begin
    reset              = 1'b1;
    load_start         = 1'b0;
    message_addr       = '0;
    digest_addr        = '0;
    hash               = '0;
    hash_done          = 1'b0;
    byte_if.byte_valid = 1'b0;
    byte_if.byte_data  = '0;
    byte_if.byte_last  = 1'b0;
    cur_base           = '0;
    cur_daddr          = '0;

    test_reset();
    test_three_byte();
    test_back_to_back();
    test_hash_capture();
    test_addr_wrap();
    test_ignored_inputs();
    test_reset_mid_load();

    step();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL pending_writes: %0d expected writes never seen, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha1_msg_loader.md
# sha1_msg_loader

Host-side front end for the SHA-1 hasher: accepts a message as a byte stream, packs it big-endian into 32-bit words and writes them into the dual-port SRAM at a given word address. It then pulses `start_hash` with the byte count, waits for the hasher's `done`, captures the 160-bit digest and writes it back to memory as five words. It is the writer/initiator on the same memory and start/done interface the hasher reads and responds on.

## Interface
- `ADDR_W`, 16: memory word-address width.
- `clk`  in  1: sole clock.
- `reset`  in  1: reset, synchronous and active-high.
- `load_start`  in  1: begin a job; sampled only in IDLE.
- `message_addr`  in  32: word address of the first message word; low `ADDR_W` bits used; latched on `load_start`.
- `digest_addr`  in  32: word address of the first digest word; latched on `load_start`.
- `byte_valid`  in  1: `byte_data` is valid.
- `byte_data`  in  8: message byte.
- `byte_last`  in  1: qualifies the final byte. Messages are 1 or more bytes.
- `byte_ready`  out  1: loader accepts a byte this cycle.
- `mem_clk`  out  1: equals `clk`.
- `mem_addr`  out  `ADDR_W`: SRAM word address.
- `mem_wdata`  out  32: SRAM write data.
- `mem_we`  out  1: SRAM write enable.
- `start_hash`  out  1: one-cycle start pulse to the hasher.
- `message_size`  out  32: message length in bytes; held stable from the `start_hash` pulse until `done`.
- `hash`  in  160: digest from the hasher.
- `hash_done`  in  1: hasher completion level.
- `digest`  out  160: captured digest; held until the next capture.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle job-complete pulse.

## Operation
- States are IDLE, LOAD, START, WAIT, WBACK, FIN.
- **IDLE:** `byte_ready`=0. On `load_start`:
  - latch both addresses;
  - clear the byte count and word index;
  - go to LOAD.
- **LOAD:** `byte_ready`=1. A byte is accepted when `byte_valid`&&`byte_ready`.
  - Bytes pack into a shift word, first byte at [31:24].
  - On the 4th byte of a word, or on the last byte, the word is written. In a partial word the unused low bytes are 0.
  - Write address = `message_addr` + word index, modulo 2^`ADDR_W`. The word index then increments.
  - Accepting the `byte_last` byte moves to START.
  - `byte_valid` low stalls LOAD indefinitely.
  - The byte count is 32-bit and wraps.
- **START:** `start_hash`=1 for exactly one cycle, `message_size`=byte count, then go to WAIT.
- **WAIT:** `hash_done` high captures `hash` into `digest`, then goes to WBACK, or to FIN if write-back is compiled out. `hash_done` is ignored in every other state.
- **WBACK:** five consecutive write cycles.
  - Word k (k=0..4) is `digest[159-32k -: 32]`, written at `digest_addr`+k (wrapping).
  - Then go to FIN.
- **FIN:** `done`=1 for one cycle, then IDLE.
- `load_start` outside IDLE is ignored. `byte_valid` outside LOAD is ignored and not consumed.

## Timing
- **Reset values:** state IDLE; `byte_ready`, `mem_we`, `start_hash`, `busy`, `done` = 0; `mem_addr`, `mem_wdata`, `message_size`, `digest` = 0.
- Reset asserted in any state aborts the job at the next edge. No pending write completes after reset.
- All outputs are registered.
- The memory write (`mem_we`/`mem_addr`/`mem_wdata`) appears the cycle after the completing byte is accepted. `mem_we` is otherwise 0.
- The last byte is accepted at cycle T:
  - its word write is at T+1;
  - `start_hash` is high at T+1;
  - WAIT begins at T+2.
- `hash_done` sampled high at cycle W:
  - `digest` is valid at W+1;
  - digest writes are at W+1..W+5;
  - `done` is at W+6.
- With write-back compiled out, `done` is at W+1.
- Throughput in LOAD is one byte per cycle; `byte_ready` never drops inside LOAD.

## Configuration
- `SHA1_DIGEST_WB_EN`
  - Defined: WBACK exists and the digest is written to SRAM as specified.
  - Undefined: WBACK is removed, WAIT goes directly to FIN, and `digest_addr` is unused. `digest` is still captured; `mem_we` is never asserted after LOAD.

## Test plan
- **3-byte message:** `message_addr`=0x10, bytes 61 62 63 with last on 63.
  - One write: addr 0x10, data 0x61626300.
  - `start_hash` pulse with `message_size`=3.
- **8-byte message:** back-to-back with `byte_valid` held high.
  - Writes at addr base and base+1 on consecutive word boundaries.
  - `byte_ready` stays 1 throughout; `message_size`=8.
- **Hash capture (WB_EN defined):** `hash_done` with `hash`=0x0123456789ABCDEFFEDCBA9876543210DEADBEEF, `digest_addr`=0x40.
  - Writes 0x01234567 at 0x40 through 0xDEADBEEF at 0x44.
  - `done` 6 cycles after `hash_done`.
- **Address wrap:** `message_addr`=0xFFFF, 5 bytes → writes at 0xFFFF then 0x0000.
- **Reset mid-LOAD:** assert `reset` after 2 bytes.
  - Next cycle all outputs are at reset values.
  - A new `load_start` restarts at word index 0.
- **Ignored inputs:** `load_start` during WAIT and `hash_done` during LOAD have no effect. The state sequence and `message_size` are unchanged.
